pit_counter_n: RTL
==================

# pit_counter_n

Parametrised successor to the single 8254-style counting element: one programmable down-counter of `WIDTH` bits, accessed over an 8-bit byte-serial bus. It adds asynchronous reset, configurable width, full BCD arithmetic, and combined counter/status read-back latches. It sits under the timer top level, one instance per channel, driven by the shared control-word decoder.

## Interface

- `WIDTH`, 16, counter width in bits; a multiple of 8, 8..32. `NB = WIDTH/8` bytes; `ND = WIDTH/4` BCD digits.
- `clkinput` in 1: single clock; all state updates on the rising edge.
- `ResetN` in 1: asynchronous, active-low reset.
- `DataIn` in 8: write byte.
- `DataOut` out 8: read byte, combinational from the read state.
- `DataOE` out 1: equals `ReadSignal`.
- `WriteSignal` in 1: one byte is written per edge while high.
- `ReadSignal` in 1: one byte is consumed per edge while high.
- `gate` in 1: counting enable / retrigger.
- `ControlWord` in 6: `[5:4]` RW, `[3:1]` mode, `[0]` BCD.
- `ChgControlWord` in 1: loads `ControlWord` at the edge.
- `EnableCounterLatch` in 1: counter-latch command.
- `EnableStatusLatch` in 1: status-latch command.
- `out` out 1: counter output.
- `CEoutput` out WIDTH: live counting element (CE).

## Operation

**Reset values**
- CW=6'b110000, CR=0, CE=0, `out`=0, null-count=1.
- Counting halted, latches empty, byte pointers 0, `DataOut`=0.

**Control word load**
- Stores CW and clears both latches and both byte pointers.
- Sets null-count=1 and halts counting until a count is written.
- `out` goes to 0 in mode 0 and to 1 in all other modes.
- If `ChgControlWord` and `WriteSignal` are both high in one edge, the control word wins and the data byte is ignored.
- Modes 6 and 7 alias to 2 and 3.
- Modes 1 and 5 are unsupported: CE holds and `out`=1.

**Count write (RW field)**
- RW=01: LSB only; upper bytes of CR are 0.
- RW=10: top byte only; other bytes are 0.
- RW=11: NB bytes, LSB first. The write pointer wraps after the last byte.
- RW=00: writes are ignored.
- CR is complete at the edge that writes its final byte. CE←CR at the next edge, and null-count clears at that same edge.
- Mode 0: `out` drops to 0 at the first byte's edge.

**Arithmetic**
- Binary: decrement modulo 2^WIDTH.
- BCD: per-digit decrement with borrow. 0 wraps to all nines (e.g. 16'h9999).
- A count of 0 means a full-range count (2^WIDTH, or 10^ND in BCD).

**Modes**
- Mode 0: CE decrements each edge while `gate`=1. `out` rises when CE becomes 0 and stays high until a new CW or count write. CE keeps wrapping.
- Mode 2 (rate generator): the edge where CE becomes 1 drives `out`=0 for exactly one clock. The next edge reloads CE←CR and sets `out`=1.
- Mode 3 (square wave): period N clocks; high for ceil(N/2) clocks, then low for floor(N/2) clocks; repeats. Internally CE steps by 2.
- Mode 4 (strobe): `out`=0 for exactly one clock after CE becomes 0. There is no reload; CE wraps and continues.

**Gate**
- Modes 0 and 4: `gate`=0 suspends decrement.
- Modes 2 and 3: `gate`=0 suspends decrement and forces `out`=1. A sampled rising edge of `gate` reloads CE←CR at the next edge.

**Read-back**
- `EnableCounterLatch`: OL←CE, unless OL already holds an unread value.
- `EnableStatusLatch`: SL←{`out`, null-count, CW}, unless SL is already latched.
- Repeated latch commands are ignored until the held value has been read.
- Read order: SL first (if latched), then the OL bytes per RW. RW=11 reads LSB first, NB bytes. If OL is not latched, the live CE bytes are read instead.
- A latch is released after its final byte is consumed.

## Timing

- Count latency: write completes at edge k; CE=CR at edge k+1; the first decrement is at k+2 if `gate`=1.
- Mode 0 with count N: `out` rises at edge k+1+N.
- A latch command at edge j freezes CE as of edge j. `CEoutput` continues to count.
- Reset asserted at any time forces the reset values immediately. Operation restarts only after a CW load or count write.

## Test plan

- Reset mid-count (mode 2 running) → `out`=0, `CEoutput`=0, `DataOut`=0 immediately; after release the block stays idle until a count is written.
- CW=6'b010000, write 8'd16, `gate`=1 → `out`=0; `out` rises at edge k+17 with `CEoutput`=0, then 16'hFFFF at the next edge.
- Mode 2 (CW=6'b010100), N=5 → `out` low for 1 clock every 5 clocks. `gate` low for 3 clocks → `out` held high; on the retrigger, CE=5 at the next edge.
- Mode 3, N=5 → 3 high / 2 low clocks. N=4 → 2 high / 2 low clocks.
- RW=11, CE counting from 16'h1234: assert both latches, then `ReadSignal` for 3 clocks → status 8'b0_0_110000 (`out`=0 after the initial mode-0 load), then 8'h34, then 8'h12 (the frozen value).
- Mode 0 BCD, CR=16'h0100 → CE steps 16'h0100 → 16'h0099 → 16'h0098. Count 0 → 16'h9999 after the first decrement.

Source files
------------

// File: rtl/pit_counter_n.sv
// One programmable down-counter channel with byte-serial access, BCD support
// and counter/status read-back latches.
module pit_counter_n #(
  parameter int WIDTH = 16
) (
  input  logic             clkinput,
  input  logic             ResetN,
  input  logic [7:0]       DataIn,
  output logic [7:0]       DataOut,
  output logic             DataOE,
  input  logic             WriteSignal,
  input  logic             ReadSignal,
  input  logic             gate,
  input  logic [5:0]       ControlWord,
  input  logic             ChgControlWord,
  input  logic             EnableCounterLatch,
  input  logic             EnableStatusLatch,
  output logic             out,
  output logic [WIDTH-1:0] CEoutput
);
  localparam int NB = WIDTH / 8;
  localparam int ND = WIDTH / 4;
  localparam logic [1:0]       LASTB = 2'(NB - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);

  logic [5:0]       cw;
  logic [WIDTH-1:0] cr, ce, ol;
  logic [7:0]       sl;
  logic             nullcnt, run, ldpend, retrig, gate_q;
  logic             ol_vld, sl_vld;
  logic [1:0]       wptr, rptr;

  logic [2:0]       mode;
  logic [1:0]       rw;
  logic             bcd;
  logic [WIDTH-1:0] d1, d2, ldval, src;
  logic             rd_ol_final;

  // Modes 6/7 behave as 2/3.
  function automatic logic [2:0] eff_mode(input logic [2:0] m);
    eff_mode = (m[2:1] == 2'b11) ? {1'b0, m[1:0]} : m;
  endfunction

  function automatic logic [WIDTH-1:0] dec1(input logic [WIDTH-1:0] v, input logic b);
    logic [WIDTH-1:0] r;
    logic             brw;
    r   = v;
    brw = 1'b1;
    if (!b) begin
      r = v - ONE;
    end else begin
      for (int i = 0; i < ND; i++) begin
        if (brw) begin
          if (v[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'd9;
          else begin
            r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
            brw = 1'b0;
          end
        end
      end
    end
    dec1 = r;
  endfunction

  always_comb begin
    mode  = eff_mode(cw[3:1]);
    rw    = cw[5:4];
    bcd   = cw[0];
    d1    = dec1(ce, bcd);
    d2    = dec1(d1, bcd);
    // Square wave counts an even value by 2; odd counts get one extra high clock.
    ldval = (mode == 3'd3) ? {cr[WIDTH-1:1], 1'b0} : cr;
  end

  always_comb begin
    src     = ol_vld ? ol : ce;
    DataOut = 8'h00;
    if (sl_vld) DataOut = sl;
    else begin
      case (rw)
        2'b01:   DataOut = src[7:0];
        2'b10:   DataOut = src[WIDTH-1 -: 8];
        2'b11:   DataOut = src[rptr*8 +: 8];
        default: DataOut = 8'h00;
      endcase
    end
  end

  assign rd_ol_final = ReadSignal && !sl_vld && (rw != 2'b11 || rptr == LASTB);
  assign DataOE      = ReadSignal;
  assign CEoutput    = ce;

  always_ff @(posedge clkinput or negedge ResetN) begin
    if (!ResetN) begin
      cw      <= 6'b110000;
      cr      <= '0;
      ce      <= '0;
      ol      <= '0;
      sl      <= '0;
      out     <= 1'b0;
      nullcnt <= 1'b1;
      run     <= 1'b0;
      ldpend  <= 1'b0;
      retrig  <= 1'b0;
      gate_q  <= 1'b0;
      ol_vld  <= 1'b0;
      sl_vld  <= 1'b0;
      wptr    <= '0;
      rptr    <= '0;
    end else begin
      gate_q <= gate;
      if (ChgControlWord) begin
        cw      <= ControlWord;
        ol_vld  <= 1'b0;
        sl_vld  <= 1'b0;
        wptr    <= '0;
        rptr    <= '0;
        nullcnt <= 1'b1;
        run     <= 1'b0;
        ldpend  <= 1'b0;
        retrig  <= 1'b0;
        out     <= (eff_mode(ControlWord[3:1]) != 3'd0);
      end else begin
        if (ldpend) begin
          ce      <= ldval;
          nullcnt <= 1'b0;
          run     <= 1'b1;
          ldpend  <= 1'b0;
          retrig  <= 1'b0;
          if (mode != 3'd0) out <= 1'b1;
        end else if (run) begin
          retrig <= gate && !gate_q && (mode == 3'd2 || mode == 3'd3);
          case (mode)
            3'd0: if (gate) begin
              ce <= d1;
              if (d1 == '0) out <= 1'b1;
            end
            3'd2: begin
              if (retrig) begin
                ce  <= cr;
                out <= 1'b1;
              end else if (!gate) out <= 1'b1;
              else if (!out) begin
                ce  <= cr;
                out <= 1'b1;
              end else begin
                ce <= d1;
                if (d1 == ONE) out <= 1'b0;
              end
            end
            3'd3: begin
              if (retrig) begin
                ce  <= ldval;
                out <= 1'b1;
              end else if (!gate) out <= 1'b1;
              else if (out) begin
                if ((ce == TWO && !cr[0]) || (ce == '0 && cr[0])) begin
                  out <= 1'b0;
                  ce  <= ldval;
                end else ce <= d2;
              end else begin
                if (ce == TWO) begin
                  out <= 1'b1;
                  ce  <= ldval;
                end else ce <= d2;
              end
            end
            3'd4: begin
              if (gate) ce <= d1;
              out <= !(gate && d1 == '0);
            end
            default: out <= 1'b1;
          endcase
        end

        // Count write; later assignments override the counting path.
        if (WriteSignal && rw != 2'b00) begin
          if (mode == 3'd0 && (rw != 2'b11 || wptr == 2'd0)) out <= 1'b0;
          case (rw)
            2'b01: begin
              cr     <= WIDTH'(DataIn);
              ldpend <= 1'b1;
            end
            2'b10: begin
              cr     <= WIDTH'(DataIn) << (WIDTH - 8);
              ldpend <= 1'b1;
            end
            default: begin
              cr[wptr*8 +: 8] <= DataIn;
              if (wptr == LASTB) begin
                wptr   <= '0;
                ldpend <= 1'b1;
              end else wptr <= wptr + 2'd1;
            end
          endcase
        end

        if (EnableCounterLatch && !ol_vld) begin
          ol     <= ce;
          ol_vld <= 1'b1;
        end else if (rd_ol_final) ol_vld <= 1'b0;

        if (EnableStatusLatch && !sl_vld) begin
          sl     <= {out, nullcnt, cw};
          sl_vld <= 1'b1;
        end else if (ReadSignal && sl_vld) sl_vld <= 1'b0;

        if (ReadSignal && !sl_vld && rw == 2'b11)
          rptr <= (rptr == LASTB) ? 2'd0 : rptr + 2'd1;
      end
    end
  end
endmodule
